// File: rtl/sph_surf_reader.sv
// Captures each committed sphere-surface accumulator result after its window closes,
// tags it with a running window index and streams it out through a small FIFO.
module sph_surf_reader #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         acc_en,
    input  logic [31:0]                  acc_dout,
    output logic [31:0]                  out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf,
    output logic [7:0]                   drop_cnt,
    input  logic                         ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_en_d;
    logic [IDX_W-1:0]  r_win_idx;
    logic [31:0]       r_mem_data [DEPTH];
    logic [IDX_W-1:0]  r_mem_idx  [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              r_ovf;
    logic [7:0]        r_drop_cnt;

    logic              w_fall;
    logic              w_capt;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;

    assign w_fall = r_en_d & ~acc_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_WAIT;
            S_WAIT:  w_next = S_CAPT;
            S_CAPT:  w_next = w_fall ? S_WAIT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The sample is taken on the edge that enters CAPT: the accumulator committed
    // one edge earlier, so acc_dout is stable throughout the WAIT cycle.
    assign w_capt = (r_state == S_WAIT);
    assign w_pop  = out_valid & out_ready;
    assign w_full = (r_level == LW'(DEPTH));
    assign w_push = w_capt & (~w_full | w_pop);
    assign w_drop = w_capt & ~w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_win_idx <= '0;
        end else begin
            r_state   <= w_next;
            r_en_d    <= acc_en;
            if (w_capt) r_win_idx <= r_win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_idx[i]  <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= acc_dout;
                r_mem_idx[r_wptr]  <= r_win_idx;
                r_wptr             <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear wins over a drop in the same cycle; that drop is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf      <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out_data  = r_mem_data[r_rptr];
    assign out_idx   = r_mem_idx[r_rptr];
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;

endmodule
